debug_loader: RTL and testbench



---
 rtl/debug_loader_pkg.sv | 10 +
 rtl/debug_loader_timer.sv | 27 ++
 rtl/debug_loader.sv | 121 ++++++++++++
 tb/tb_debug_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_loader_pkg.sv
// debug_loader_pkg: shared FSM state encoding and frame header sizes for the debug program loader.
package debug_loader_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, CNT, DATA, WSETUP, WSTROBE, CSUM, DONE, ERR
    } state_t;

    localparam int ADDR_BYTES = 4;
    localparam int CNT_BYTES  = 2;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/debug_loader_timer.sv
// loader_timer: inter-byte idle counter; expired flags the TIMEOUT-th consecutive idle cycle.
// Ports: clk, rst (async, active-high), clr (restart count), en (count this cycle), expired (out).
module loader_timer #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    // Counting stops at TIMEOUT-1, so an idle cycle seen with expired high is the TIMEOUT-th.
    assign expired = count == W'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && !expired)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/debug_loader.sv
// debug_loader: framed byte stream to core debug program-load port, one strobe per 32-bit word.
// Ports: clk, rst (async, active-high); in_data/in_valid/in_ready byte handshake;
//        DEBUG_SIG load mode, DEBUG_addr/DEBUG_instr write target, debug_wr write strobe;
//        done/err sticky result of the last frame.
module debug_loader
    import debug_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_WORDS = 4096,
    parameter int         TIMEOUT   = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        DEBUG_SIG,
    output logic [31:0] DEBUG_addr,
    output logic [31:0] DEBUG_instr,
    output logic        debug_wr,
    output logic        done,
    output logic        err
);
    state_t      state, next;
    logic [1:0]  bcnt;
    logic [15:0] wcnt;
    logic [31:0] sh;
    logic [7:0]  csum;
    logic        acc, last, counting, expired;
    logic [31:0] word;
    logic [15:0] nwords;

    // Bytes shift in from the top, so after the last byte of a field the value is little-endian.
    assign word   = {in_data, sh[31:8]};
    assign nwords = {in_data, sh[31:24]};

    loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc || state == IDLE),
        .en      (counting),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        in_ready = state inside {IDLE, ADDR, CNT, DATA, CSUM};
        counting = state inside {ADDR, CNT, DATA, CSUM};
        acc      = in_valid && in_ready;
        last     = state == CNT  ? bcnt == 2'(CNT_BYTES - 1)  :
                   state == ADDR ? bcnt == 2'(ADDR_BYTES - 1) : bcnt == 2'(WORD_BYTES - 1);
        next     = state;
        if (counting && !acc && expired)
            next = ERR;
        else
            case (state)
                IDLE:    if (acc && in_data == SYNC_BYTE) next = ADDR;
                ADDR:    if (acc && last) next = word[1:0] != 2'b00 ? ERR : CNT;
                CNT:     if (acc && last) next = (nwords == 16'd0 || {16'd0, nwords} > 32'(MAX_WORDS)) ? ERR : DATA;
                DATA:    if (acc && last) next = WSETUP;
                WSETUP:  next = WSTROBE;
                WSTROBE: next = wcnt == 16'd1 ? CSUM : DATA;
                CSUM:    if (acc) next = in_data == csum ? DONE : ERR;
                default: next = IDLE;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DEBUG_SIG   <= 1'b0;
            DEBUG_addr  <= '0;
            DEBUG_instr <= '0;
            debug_wr    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            bcnt        <= '0;
            wcnt        <= '0;
            sh          <= '0;
            csum        <= '0;
        end else begin
            // Strobe is registered from WSETUP so it is high exactly during WSTROBE.
            debug_wr <= state == WSETUP;
            if (state == IDLE && acc && in_data == SYNC_BYTE) begin
                DEBUG_SIG <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
                csum      <= '0;
                bcnt      <= '0;
            end
            if (acc && state inside {ADDR, CNT, DATA}) begin
                sh   <= word;
                csum <= csum ^ in_data;
                bcnt <= last ? 2'd0 : bcnt + 2'd1;
            end
            if (acc && last && state == ADDR)
                DEBUG_addr <= word;
            if (acc && last && state == CNT)
                wcnt <= nwords;
            if (acc && last && state == DATA)
                DEBUG_instr <= word;
            if (state == WSTROBE) begin
                wcnt       <= wcnt - 16'd1;
                DEBUG_addr <= DEBUG_addr + 32'd4;
            end
            if (state == DONE) begin
                done      <= 1'b1;
                DEBUG_SIG <= 1'b0;
            end
            if (state == ERR) begin
                err       <= 1'b1;
                DEBUG_SIG <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_debug_loader.sv
// tb_debug_loader: randomized frames against a frame-level model of expected writes and result flags.
module tb_debug_loader;
    localparam int TO   = 16;
    localparam int MAXW = 4096;

    logic        clk, rst;
    logic [7:0]  in_data;
    logic        in_valid, in_ready;
    logic        DEBUG_SIG, debug_wr, done, err;
    logic [31:0] DEBUG_addr, DEBUG_instr;

    debug_loader #(.SYNC_BYTE(8'hA5), .MAX_WORDS(MAXW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .DEBUG_SIG   (DEBUG_SIG),
        .DEBUG_addr  (DEBUG_addr),
        .DEBUG_instr (DEBUG_instr),
        .debug_wr    (debug_wr),
        .done        (done),
        .err         (err)
    );

    int          total = 0;
    int          bad   = 0;
    int          nstrobe = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  bq[$];
    logic [31:0] wq[$];
    logic [7:0]  mc;
    bit          exp_err;
    int          sync_idx;
    logic        prev_ready = 1'b1;
    logic        prev_wr = 1'b0;
    logic [31:0] prev_addr = '0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every strobe must match the next expected (addr, word) and occur with the loader stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_wr = 1'b0;
        end else begin
            if (prev_wr)
                chk("addr_inc", DEBUG_addr, prev_addr + 32'd4);
            if (debug_wr) begin
                chk("wr_ready", in_ready, 0);
                chk("wr_prev_ready", prev_ready, 0);
                if (exp_q.size() == 0)
                    chk("wr_extra", exp_q.size() + 1, 0);
                else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", DEBUG_addr, e[63:32]);
                    chk("wr_instr", DEBUG_instr, e[31:0]);
                end
                nstrobe++;
            end
            prev_wr   = debug_wr;
            prev_addr = DEBUG_addr;
        end
        prev_ready = in_ready;
    end

    function automatic void pb(input logic [7:0] b);
        bq.push_back(b);
        mc ^= b;
    endfunction

    function automatic void build(input logic [31:0] a, input logic [15:0] n, input bit bad_cs);
        logic [7:0] j;
        bq.delete();
        mc = '0;
        repeat ($urandom_range(2, 0)) begin
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h5A;
            bq.push_back(j);
        end
        sync_idx = bq.size();
        bq.push_back(8'hA5);
        for (int i = 0; i < 4; i++) pb(a[8*i +: 8]);
        exp_err = bad_cs;
        if (a[1:0] != 2'b00) begin
            exp_err = 1;
            return;
        end
        pb(n[7:0]);
        pb(n[15:8]);
        if (n == 16'd0 || int'(n) > MAXW) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 4; k++) pb(wq[i][8*k +: 8]);
            exp_q.push_back({a + 32'(4 * i), wq[i]});
        end
        bq.push_back(mc ^ {7'd0, bad_cs});
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gmax);
        int g;
        g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
        in_valid = 0;
        repeat (g) @(negedge clk);
        in_data  = b;
        in_valid = 1;
        for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
        chk("accept", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [31:0] a, input logic [15:0] n, input bit bad_cs, input int gmax);
        build(a, n, bad_cs);
        foreach (bq[i]) begin
            send_byte(bq[i], gmax);
            if (i == sync_idx) chk("sig_rise", DEBUG_SIG, 1);
        end
        in_valid = 0;
        chk("sig_hold", DEBUG_SIG, 1);
        chk("flags_mid", {done, err}, 0);
        @(negedge clk);
        chk("done", done, !exp_err);
        chk("err", err, exp_err);
        chk("sig_low", DEBUG_SIG, 0);
        chk("strobes_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    initial begin
        int base;
        rst = 1; in_valid = 0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_flags", {DEBUG_SIG, debug_wr, done, err}, 0);
        chk("rst_addr", DEBUG_addr, 0);
        chk("rst_instr", DEBUG_instr, 0);
        rst = 0;
        @(negedge clk);

        wq = '{32'h0000_0013, 32'h0010_0093};
        run_frame(32'h0000_0100, 16'd2, 0, 0);
        run_frame(32'h0000_0100, 16'd2, 1, 0);
        run_frame(32'h0000_0102, 16'd2, 0, 0);
        run_frame(32'h0000_0100, 16'd0, 0, 0);
        run_frame(32'h0000_0100, 16'd4097, 0, 0);

        // Stall inside DATA until the idle timer expires, then restart cleanly.
        rand_words(2);
        build(32'h0000_0200, 16'd2, 0);
        for (int i = 0; i <= sync_idx + 8; i++) send_byte(bq[i], 0);
        in_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == TO / 2) chk("to_early", err, 0);
            if (k == 20) chk("to_err", err, 1);
            @(negedge clk);
        end
        chk("to_sig", DEBUG_SIG, 0);
        chk("to_nowr", exp_q.size(), 2);
        exp_q.delete();
        rand_words(1);
        run_frame(32'h0000_0300, 16'd1, 0, 1);

        // Reset between the 2nd and 3rd word of a 3-word frame.
        rand_words(3);
        build(32'h0000_0400, 16'd3, 0);
        base = nstrobe;
        for (int i = 0; i <= sync_idx + 14; i++) send_byte(bq[i], 0);
        in_valid = 0;
        for (int w = 0; w < 10 && nstrobe < base + 2; w++) @(negedge clk);
        chk("rr_strobes", nstrobe - base, 2);
        rst = 1;
        #1;
        chk("rr_flags", {DEBUG_SIG, debug_wr, done, err}, 0);
        chk("rr_addr", DEBUG_addr, 0);
        chk("rr_instr", DEBUG_instr, 0);
        @(negedge clk);
        rst = 0;
        repeat (12) @(negedge clk);
        chk("rr_nowr", nstrobe - base, 2);
        chk("rr_after", {DEBUG_SIG, done, err}, 0);
        exp_q.delete();
        rand_words(2);
        run_frame(32'h0000_0500, 16'd2, 0, 0);

        // Address wrap with a mid-frame SYNC value inside data.
        wq = '{32'hA5A5_00A5, $urandom};
        run_frame(32'hFFFF_FFFC, 16'd2, 0, 3);

        for (int f = 0; f < 8; f++) begin
            logic [31:0] a;
            int n;
            a = $urandom & 32'hFFFF_FFFC;
            n = $urandom_range(4, 1);
            rand_words(n);
            run_frame(a, 16'(n), $urandom_range(3, 0) == 0, $urandom_range(3, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
